// File: rtl/fwd_scoreboard.sv
// Post-EX forwarding scoreboard: tracks in-flight destination registers, muxes
// forwarded results onto the branch/ALU operands and raises load-use stalls.

// One operand's forward selector: youngest matching entry wins.
module fwd_operand #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 1
) (
    input  logic [4:0]                  src,
    input  logic [XLEN-1:0]             reg_val,
    input  logic [DEPTH-1:0]            ent_vld,
    input  logic [DEPTH-1:0]            ent_we,
    input  logic [DEPTH-1:0]            ent_ld,
    input  logic [DEPTH-1:0][4:0]       ent_rd,
    input  logic [DEPTH-1:0][XLEN-1:0]  data,
    output logic [XLEN-1:0]             val,
    output logic                        hit,
    output logic                        hazard
);
    // Oldest-to-youngest scan so the lowest index overwrites; the hazard is
    // taken from the winning entry only, so an older ALU result never hides
    // a younger load.
    always_comb begin
        val    = reg_val;
        hit    = 1'b0;
        hazard = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_vld[k] && ent_we[k] && (ent_rd[k] == src) && (src != 5'd0)) begin
                val    = data[k];
                hit    = 1'b1;
                hazard = ent_ld[k] && (k < LOAD_STAGE);
            end
        end
    end
endmodule

module fwd_scoreboard #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [4:0]              ex_rd,
    input  logic                    ex_we,
    input  logic                    ex_is_load,
    input  logic [4:0]              ex_rs1_addr,
    input  logic [4:0]              ex_rs2_addr,
    input  logic [XLEN-1:0]         rs1,
    input  logic [XLEN-1:0]         rs2,
    input  logic [XLEN-1:0]         pc,
    input  logic [XLEN-1:0]         imm,
    input  logic                    asel_pc,
    input  logic                    bsel_imm,
    input  logic                    flush,
    input  logic [DEPTH*XLEN-1:0]   stage_data,
    output logic [XLEN-1:0]         alu_a,
    output logic [XLEN-1:0]         alu_b,
    output logic [XLEN-1:0]         br_a,
    output logic [XLEN-1:0]         br_b,
    output logic [1:0]              fwd_hit,
    output logic                    load_use_stall,
    output logic [15:0]             stall_cycles
);
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0]            we_pipe;
    logic [DEPTH-1:0]            ld_pipe;
    logic [DEPTH-1:0][4:0]       rd_pipe;
    logic [DEPTH-1:0][XLEN-1:0]  data;

    logic [1:0][4:0]             src;
    logic [1:0][XLEN-1:0]        reg_val;
    logic [1:0][XLEN-1:0]        fwd_val;
    logic [1:0]                  hazard;
    logic                        ent0_vld;

    assign data    = stage_data;
    assign src     = {ex_rs2_addr, ex_rs1_addr};
    assign reg_val = {rs2, rs1};

    for (genvar i = 0; i < 2; i++) begin : g_op
        fwd_operand #(
            .XLEN       (XLEN),
            .DEPTH      (DEPTH),
            .LOAD_STAGE (LOAD_STAGE)
        ) u_op (
            .src     (src[i]),
            .reg_val (reg_val[i]),
            .ent_vld (vld_pipe),
            .ent_we  (we_pipe),
            .ent_ld  (ld_pipe),
            .ent_rd  (rd_pipe),
            .data    (data),
            .val     (fwd_val[i]),
            .hit     (fwd_hit[i]),
            .hazard  (hazard[i])
        );
    end

    assign br_a  = fwd_val[0];
    assign br_b  = fwd_val[1];
    assign alu_a = asel_pc  ? pc  : br_a;
    assign alu_b = bsel_imm ? imm : br_b;

    // flush wins over the stall; a stalled EX instruction re-issues later,
    // so entry 0 gets a bubble while the load keeps moving.
    assign load_use_stall = ex_valid && !flush && (|hazard);
    assign ent0_vld       = ex_valid && !flush && !load_use_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe     <= '0;
            stall_cycles <= 16'd0;
        end else begin
            vld_pipe <= {vld_pipe[DEPTH-2:0], ent0_vld};
            if (load_use_stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

    // Payload fields are qualified by vld_pipe and need no reset.
    always_ff @(posedge clk) begin
        rd_pipe <= {rd_pipe[DEPTH-2:0], ex_rd};
        we_pipe <= {we_pipe[DEPTH-2:0], ex_we};
        ld_pipe <= {ld_pipe[DEPTH-2:0], ex_is_load};
    end
endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width.
REQ-002 SHALL provide parameter DEPTH, default 2, number of tracked post-EX stages (legal range 2..8).
REQ-003 SHALL provide parameter LOAD_STAGE, default 1, first entry index where load data is valid (legal range 1..DEPTH-1).
REQ-004 SHALL have ports:
  clk  in  1  rising-edge clock.
  rst  in  1  synchronous active-high reset.
  ex_valid  in  1  EX-stage instruction valid.
  ex_rd  in  5  EX destination register.
  ex_we  in  1  EX writes rd.
  ex_is_load  in  1  EX instruction is a load.
  ex_rs1_addr, ex_rs2_addr  in  5 each  EX source registers.
  rs1, rs2  in  XLEN each  register-file read values.
  pc, imm  in  XLEN each  EX pc and immediate.
  asel_pc  in  1  ALU A takes pc.
  bsel_imm  in  1  ALU B takes imm.
  flush  in  1  kill EX instruction.
  stage_data  in  DEPTH*XLEN  result held by entry k at bits [k*XLEN +: XLEN].
  alu_a, alu_b  out  XLEN each  ALU operands.
  br_a, br_b  out  XLEN each  branch-compare operands.
  fwd_hit  out  2  {rs2 forwarded, rs1 forwarded}.
  load_use_stall  out  1  hold EX and earlier stages.
  stall_cycles  out  16  saturating count of stall cycles.

Function
REQ-005 SHALL keep DEPTH entries {valid, rd, we, is_load}; entry 0 youngest (just left EX), entry DEPTH-1 oldest.
REQ-006 Each clk edge without rst SHALL shift entry k to k+1 (k < DEPTH-1) and drop entry DEPTH-1.
REQ-007 Entry 0 SHALL load {1, ex_rd, ex_we, ex_is_load} when ex_valid=1, flush=0, load_use_stall=0; otherwise SHALL load a bubble (valid=0).
REQ-008 Entry k SHALL match source s when valid, we, rd==s and s!=0.
REQ-009 Forward source for each operand SHALL be the lowest-index matching entry; no match selects rs1/rs2.
REQ-010 Register x0 SHALL never be forwarded; source 0 yields rs1/rs2 unchanged.
REQ-011 br_a SHALL equal forwarded rs1 value; br_b forwarded rs2 value; combinational, zero latency.
REQ-012 alu_a SHALL equal pc when asel_pc=1, else br_a; alu_b SHALL equal imm when bsel_imm=1, else br_b.
REQ-013 fwd_hit[0]/[1] SHALL be 1 iff rs1/rs2 select a stage_data slot (independent of asel_pc/bsel_imm).
REQ-014 load_use_stall SHALL be 1 iff ex_valid=1, flush=0, and for either source the selected entry has is_load=1 and index < LOAD_STAGE.
REQ-015 An older non-load match SHALL NOT mask a younger load match (priority per REQ-009 applies first).
REQ-016 During stall the bubble enters entry 0 while the load advances; stall SHALL release automatically once the load reaches LOAD_STAGE.
REQ-017 flush=1 SHALL override stall (load_use_stall=0) and insert a bubble.
REQ-018 stall_cycles SHALL increment by 1 on each edge with load_use_stall=1, saturating at 16'hFFFF.
REQ-019 Outputs with ex_valid=0 SHALL still follow REQ-009..REQ-012 (values don't-care downstream).

Reset
REQ-020 rst=1 at an edge SHALL clear all entry valid bits and stall_cycles to 0, overriding all other inputs.
REQ-021 After reset, fwd_hit=2'b00, load_use_stall=0, br_a=rs1, br_b=rs2 until an entry is written.
REQ-022 Reset mid-stall SHALL drop load_use_stall to 0 in the cycle following the reset edge.

Verification
REQ-023 ALU chain: write x5 (non-load) enters entry 0, next EX reads rs1=x5, stage_data[0]=32'h1234 -> br_a=alu_a=32'h1234, fwd_hit=2'b01, no stall.
REQ-024 Priority: entry 0 rd=x7 data 32'hAAAA, entry 1 rd=x7 data 32'hBBBB, EX rs2=x7, bsel_imm=0 -> alu_b=32'hAAAA; with bsel_imm=1, imm=32'h10 -> alu_b=32'h10, br_b=32'hAAAA.
REQ-025 Load-use (DEPTH=2, LOAD_STAGE=1): load x3 into entry 0, EX rs1=x3 -> load_use_stall=1 exactly one cycle, then br_a=stage_data[1], stall_cycles=1.
REQ-026 x0: entry 0 rd=x0 we=1, EX rs1=x0, rs1=0 -> br_a=0, fwd_hit[0]=0.
REQ-027 Flush: load hazard present with flush=1 -> load_use_stall=0, entry 0 bubble next cycle, stall_cycles unchanged.
REQ-028 Reset mid-operation: assert rst during stall with stall_cycles=5 -> next cycle stall_cycles=0, load_use_stall=0, fwd_hit=2'b00.
